// File: rtl/adc_emu_spi_if.sv
// adc_emu_spi_if: SPI pin bundle between an ADC SPI master and the
// AD7476A emulator.
//   adc_cs_n    - chip select, driven by the master, active low
//   adc_sclk    - serial clock, driven by the master, idles low
//   adc_miso    - serial data back to the master
//   adc_miso_oe - pad enable for adc_miso, high while a frame is active
interface adc_emu_spi_if;
  logic adc_cs_n;
  logic adc_sclk;
  logic adc_miso;
  logic adc_miso_oe;

  modport master (output adc_cs_n, adc_sclk, input  adc_miso, adc_miso_oe);
  modport slave  (input  adc_cs_n, adc_sclk, output adc_miso, adc_miso_oe);
endinterface

// File: rtl/adc_emu_spi.sv
// adc_emu_spi: SPI slave emulating the AD7476A 12-bit ADC serial interface.
// CS_n and SCLK are oversampled on clk. Each frame returns 16 bits on MISO,
// MSB first: four leading zeros, then a 12-bit sample.
//
// Ports:
//   clk, rst     - system clock; synchronous active-high reset
//   spi (slave)  - adc_cs_n / adc_sclk in, adc_miso / adc_miso_oe out
//   sample_in    - 12-bit value returned in the next frame
//   sample_ack   - 1-cycle pulse when sample_in is latched (CS fall)
//   frame_done   - 1-cycle pulse when CS rises after 16 SCLK falls
//   frame_abort  - 1-cycle pulse when CS rises before 16 SCLK falls
//   frame_count  - completed frames, wraps 0xFFFF -> 0
//
// Optional build macro ADC_EMU_RAMP_EN: an internal 12-bit ramp replaces
// sample_in as the frame source and advances by RAMP_STEP on each
// frame_done (never on an abort).
module adc_emu_spi #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [11:0] RAMP_STEP   = 12'd1
) (
  input  logic        clk,
  input  logic        rst,
  adc_emu_spi_if.slave spi,
  input  logic [11:0] sample_in,
  output logic        sample_ack,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, QUIET} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync;
  logic                   cs_hist, sclk_hist;
  logic [15:0]            shreg;
  logic [3:0]             fall_cnt;
  logic                   miso_q, oe_q;
  logic [11:0]            frame_src;

  assign spi.adc_miso    = miso_q;
  assign spi.adc_miso_oe = oe_q;

  // CS resets high and SCLK low so reset never fakes an edge from idle pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync   <= '1;
      cs_hist   <= 1'b1;
      sclk_sync <= '0;
      sclk_hist <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.adc_cs_n};
      cs_hist   <= cs_sync[SYNC_STAGES-1];
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.adc_sclk};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
    end
  end

  wire cs_fall   =  cs_hist   & ~cs_sync[SYNC_STAGES-1];
  wire cs_rise   = ~cs_hist   &  cs_sync[SYNC_STAGES-1];
  wire sclk_fall =  sclk_hist & ~sclk_sync[SYNC_STAGES-1];

`ifdef ADC_EMU_RAMP_EN
  logic [11:0] ramp;
  logic        unused_sample_in;
  assign frame_src        = ramp;
  assign unused_sample_in = ^sample_in;
`else
  // Keeps the ramp step referenced when the ramp source is compiled out.
  logic unused_ramp_step;
  assign frame_src        = sample_in;
  assign unused_ramp_step = ^RAMP_STEP;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      fall_cnt    <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      sample_ack  <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      frame_count <= '0;
`ifdef ADC_EMU_RAMP_EN
      ramp        <= '0;
`endif
    end else begin
      sample_ack  <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            shreg      <= {4'b0000, frame_src};
            sample_ack <= 1'b1;
            oe_q       <= 1'b1;
            miso_q     <= 1'b0;  // frame bit 15 is always a leading zero
            fall_cnt   <= '0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          // CS rise wins over a same-cycle SCLK edge.
          if (cs_rise) begin
            oe_q        <= 1'b0;
            miso_q      <= 1'b0;
            frame_abort <= 1'b1;
            state       <= IDLE;
          end else if (sclk_fall) begin
            fall_cnt <= fall_cnt + 4'd1;
            shreg    <= {shreg[14:0], 1'b0};
            if (fall_cnt == 4'd15) begin
              miso_q <= 1'b0;
              state  <= QUIET;
            end else begin
              miso_q <= shreg[14];
            end
          end
        end
        QUIET: begin
          if (cs_rise) begin
            oe_q        <= 1'b0;
            miso_q      <= 1'b0;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
`ifdef ADC_EMU_RAMP_EN
            ramp        <= ramp + RAMP_STEP;
`endif
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
